// File: rtl/ntt_pkg.sv
// Shared constants for the Kyber-style (Q=3329) NTT/INTT datapath.
// INTT_HALVE_EN adds one per-stage halving register to the inverse butterfly.
package ntt_pkg;
    localparam int DATA_WIDTH        = 12;
    localparam int Q                 = 3329;
    localparam int NTT_STAGE_CNT     = 8;
    localparam int MUL_STAGE_CNT     = 3;
    localparam int ADD_SUB_STAGE_CNT = 1;
    localparam int INTT_R2_MONT      = 2285;
    localparam int MONT_BITS         = 16;
    // -Q^-1 mod 2^16, used to build the Montgomery correction term
    localparam int MONT_QNEG_INV     = 3327;
    localparam int ADDR_W            = NTT_STAGE_CNT - 1;
    localparam int FRAME_BEATS       = 1 << ADDR_W;
`ifdef INTT_HALVE_EN
    localparam int HALVE_STAGE_CNT   = 1;
`else
    localparam int HALVE_STAGE_CNT   = 0;
`endif
endpackage

// File: rtl/gs_butterfly.sv
// Gentleman-Sande butterfly: (u+v, (u-v)*zeta*2^-16) mod Q, fully pipelined.
// Build option INTT_HALVE_EN appends a stage that halves both outputs mod Q.
module gs_butterfly
    import ntt_pkg::*;
(
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] i_u,
    input  logic [DATA_WIDTH-1:0] i_v,
    input  logic [DATA_WIDTH-1:0] i_zeta,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic [DATA_WIDTH-1:0] o_prod
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = MONT_BITS + DATA_WIDTH + 1;

    function automatic logic [DATA_WIDTH-1:0] mod_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (DATA_WIDTH+1)'(Q)) s = s - (DATA_WIDTH+1)'(Q);
        return s[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mod_sub(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH+1:0] d;
        d = $signed({2'b00, a}) - $signed({2'b00, b});
        if (d[DATA_WIDTH+1]) d = d + $signed((DATA_WIDTH+2)'(Q));
        return d[DATA_WIDTH-1:0];
    endfunction

    // (t + m*Q) is an exact multiple of 2^16 and below 2Q*2^16
    function automatic logic [DATA_WIDTH-1:0] mont_reduce(input logic [PW-1:0] t,
                                                          input logic [MONT_BITS-1:0] m);
        logic [AW-1:0]       acc;
        logic [DATA_WIDTH:0] r;
        acc = AW'(t) + AW'(m) * AW'(Q);
        r   = acc[AW-1:MONT_BITS];
        if (r >= (DATA_WIDTH+1)'(Q)) r = r - (DATA_WIDTH+1)'(Q);
        return r[DATA_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] r_sum_p0, r_diff_p0;
    logic [DATA_WIDTH-1:0] r_sum_p1, r_sum_p2, r_sum_p3, r_prod_p3;
    logic [PW-1:0]         r_t_p1, r_t_p2;
    logic [MONT_BITS-1:0]  r_m_p2;

    always_ff @(posedge clk) begin
        // p0: modular add/sub
        r_sum_p0  <= mod_add(i_u, i_v);
        r_diff_p0 <= mod_sub(i_u, i_v);
        // p1: raw product
        r_t_p1    <= PW'(r_diff_p0) * PW'(i_zeta);
        r_sum_p1  <= r_sum_p0;
        // p2: Montgomery correction factor
        r_t_p2    <= r_t_p1;
        r_m_p2    <= MONT_BITS'(r_t_p1[MONT_BITS-1:0] * MONT_BITS'(MONT_QNEG_INV));
        r_sum_p2  <= r_sum_p1;
        // p3: reduced product
        r_prod_p3 <= mont_reduce(r_t_p2, r_m_p2);
        r_sum_p3  <= r_sum_p2;
    end

`ifdef INTT_HALVE_EN
    function automatic logic [DATA_WIDTH-1:0] halve(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + (DATA_WIDTH+1)'(Q)) : {1'b0, x};
        return s[DATA_WIDTH:1];
    endfunction

    logic [DATA_WIDTH-1:0] r_sum_p4, r_prod_p4;

    always_ff @(posedge clk) begin
        // p4: multiply by 2^-1 mod Q
        r_sum_p4  <= halve(r_sum_p3);
        r_prod_p4 <= halve(r_prod_p3);
    end

    assign o_sum  = r_sum_p4;
    assign o_prod = r_prod_p4;
`else
    assign o_sum  = r_sum_p3;
    assign o_prod = r_prod_p3;
`endif
endmodule

// File: rtl/intt_stage.sv
// One inverse-NTT stage: optional delay commutator, twiddle addressing, GS butterfly.
// Build option INTT_HALVE_EN lengthens the latency by one halving stage.
module intt_stage
    import ntt_pkg::*;
#(
    parameter int REORDER      = 0,
    parameter int SWITCH_INDEX = 0,
    parameter int ROM_SHIFT    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_in_en,
    input  logic [1:0][DATA_WIDTH-1:0] i_in,
    output logic                       o_out_en,
    output logic [1:0][DATA_WIDTH-1:0] o_out,
    output logic [ADDR_W-1:0]          o_rom_addr,
    input  logic [DATA_WIDTH-1:0]      i_rom_data
);
    localparam int H = 1 << SWITCH_INDEX;
    localparam int R = (REORDER != 0) ? H + 1 : 0;
    localparam int L = R + ADD_SUB_STAGE_CNT + MUL_STAGE_CNT + HALVE_STAGE_CNT;

    logic [L-1:0]          r_en_sr;
    logic [ADDR_W-1:0]     r_cnt;
    logic [DATA_WIDTH-1:0] w_u, w_v;
    logic [ADDR_W-1:0]     w_bidx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en_sr <= '0;
            r_cnt   <= '0;
        end else begin
            r_en_sr <= {r_en_sr[L-2:0], i_in_en};
            // frame length is 2^ADDR_W, so the natural wrap is the frame wrap
            r_cnt   <= i_in_en ? r_cnt + 1'b1 : '0;
        end
    end

    generate
        if (REORDER != 0) begin : g_reorder
            logic [DATA_WIDTH-1:0] r_bufa [H];
            logic [DATA_WIDTH-1:0] r_bufb [H];
            logic [DATA_WIDTH-1:0] r_u_p0, r_v_p0;
            logic [ADDR_W-1:0]     r_cntp;
            logic                  w_swap;
            logic                  w_en_rd;

            assign w_swap  = r_cnt[SWITCH_INDEX];
            assign w_en_rd = r_en_sr[R-1];

            // In the second half of a group lane 0's buffer is refilled with
            // lane 1's delayed data so it surfaces 2H beats after entry.
            always_ff @(posedge clk) begin
                r_bufa[0] <= w_swap ? r_bufb[H-1] : i_in[0];
                r_bufb[0] <= i_in[1];
                for (int i = 1; i < H; i++) begin
                    r_bufa[i] <= r_bufa[i-1];
                    r_bufb[i] <= r_bufb[i-1];
                end
                // p0: reordered butterfly pair
                r_u_p0 <= r_bufa[H-1];
                r_v_p0 <= w_swap ? i_in[0] : r_bufb[H-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_cntp <= '0;
                else     r_cntp <= w_en_rd ? r_cntp + 1'b1 : '0;
            end

            assign w_u    = r_u_p0;
            assign w_v    = r_v_p0;
            assign w_bidx = r_cntp;
        end else begin : g_direct
            assign w_u    = i_in[0];
            assign w_v    = i_in[1];
            assign w_bidx = r_cnt;
        end
    endgenerate

    // Synchronous ROM: zeta arrives exactly when the difference leaves add/sub
    assign o_rom_addr = w_bidx >> ROM_SHIFT;
    assign o_out_en   = r_en_sr[L-1];

    gs_butterfly u_bfly (
        .clk    (clk),
        .i_u    (w_u),
        .i_v    (w_v),
        .i_zeta (i_rom_data),
        .o_sum  (o_out[0]),
        .o_prod (o_out[1])
    );
endmodule

// File: tb/tb_intt_stage.sv
// Directed bench for intt_stage: a direct stage (A) and a commutator stage (B).
// Expected values follow INTT_HALVE_EN when that macro is defined.
module tb_intt_stage;
    import ntt_pkg::*;

`ifdef INTT_HALVE_EN
    localparam int HV = 1;
`else
    localparam int HV = 0;
`endif
    localparam int LA = 4 + HV;
    localparam int LB = 7 + HV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rom_mode = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic                       a_en, b_en, a_oen, b_oen;
    logic [1:0][DATA_WIDTH-1:0] a_in, b_in, a_out, b_out;
    logic [ADDR_W-1:0]          a_addr, b_addr;
    logic [DATA_WIDTH-1:0]      a_rom, b_rom;

    int qa_s[$], qa_p[$], qa_c[$];
    int qb_s[$], qb_p[$], qb_c[$];

    always #5 clk = ~clk;

    intt_stage #(.REORDER(0), .SWITCH_INDEX(0), .ROM_SHIFT(1)) dut_a (
        .clk(clk), .rst(rst), .i_in_en(a_en), .i_in(a_in), .o_out_en(a_oen),
        .o_out(a_out), .o_rom_addr(a_addr), .i_rom_data(a_rom));

    intt_stage #(.REORDER(1), .SWITCH_INDEX(1), .ROM_SHIFT(0)) dut_b (
        .clk(clk), .rst(rst), .i_in_en(b_en), .i_in(b_in), .o_out_en(b_oen),
        .o_out(b_out), .o_rom_addr(b_addr), .i_rom_data(b_rom));

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        a_rom <= rom_mode ? DATA_WIDTH'(a_addr) : DATA_WIDTH'(INTT_R2_MONT);
        b_rom <= rom_mode ? DATA_WIDTH'(b_addr) : DATA_WIDTH'(INTT_R2_MONT);
    end

    always @(negedge clk) begin
        if (a_oen === 1'b1) begin
            qa_s.push_back(int'(a_out[0])); qa_p.push_back(int'(a_out[1])); qa_c.push_back(cyc);
        end
        if (b_oen === 1'b1) begin
            qb_s.push_back(int'(b_out[0])); qb_p.push_back(int'(b_out[1])); qb_c.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int hv(input int x);
`ifdef INTT_HALVE_EN
        return (x % 2 == 1) ? (x + Q) / 2 : x / 2;
`else
        return x;
`endif
    endfunction

    // x such that x * 2^16 == a (mod Q)
    function automatic int mont_ref(input int a);
        for (int x = 0; x < Q; x++)
            if ((x * 65536) % Q == a % Q) return x;
        return -1;
    endfunction

    task automatic single_a(input int u, input int v, input int es, input int ep);
        a_in[0] = DATA_WIDTH'(u);
        a_in[1] = DATA_WIDTH'(v);
        a_en = 1'b1;
        for (int j = 1; j <= LA + 1; j++) begin
            step;
            a_en = 1'b0;
            chk("a_oen_latency", 32'(a_oen), 32'(j == LA));
            if (j == LA) begin
                chk("a_sum", 32'(a_out[0]), es);
                chk("a_prod", 32'(a_out[1]), ep);
            end
        end
    endtask

    task automatic stream_a(input int n);
        int c0;
        qa_s.delete(); qa_p.delete(); qa_c.delete();
        a_in[0] = DATA_WIDTH'(1);
        a_in[1] = DATA_WIDTH'(0);
        c0 = cyc;
        for (int k = 0; k < n; k++) begin
            a_en = 1'b1;
            chk("a_rom_addr", 32'(a_addr), 32'((k % FRAME_BEATS) >> 1));
            step;
        end
        a_en = 1'b0;
        repeat (LA + 2) step;
        chk("a_stream_beats", qa_c.size(), n);
        if (qa_c.size() == n) begin
            chk("a_stream_latency", qa_c[0] - c0, LA);
            for (int i = 0; i < n; i++) begin
                chk("a_stream_contig", qa_c[i] - qa_c[0], i);
                chk("a_stream_sum", qa_s[i], hv(1));
                chk("a_stream_prod", qa_p[i], hv(mont_ref((i % FRAME_BEATS) >> 1)));
            end
        end
        chk("a_rom_addr_idle", 32'(a_addr), 0);
    endtask

    initial begin
        int es[4];
        int c0;
        es = '{4, 8, 6, 10};
        a_en = 1'b0; b_en = 1'b0; a_in = '0; b_in = '0;

        repeat (3) step;
        chk("rst_a_oen", 32'(a_oen), 0);
        chk("rst_b_oen", 32'(b_oen), 0);
        chk("rst_a_addr", 32'(a_addr), 0);
        chk("rst_b_addr", 32'(b_addr), 0);
        rst = 1'b0;
        step;

        single_a(5, 3, hv(8), hv(2));
        single_a(3, 5, hv(8), hv(3327));

        rom_mode = 1'b1;
        stream_a(FRAME_BEATS);
        stream_a(2 * FRAME_BEATS);
        rom_mode = 1'b0;

        a_in[0] = DATA_WIDTH'(5); a_in[1] = DATA_WIDTH'(3);
        b_in[0] = DATA_WIDTH'(100); b_in[1] = DATA_WIDTH'(200);
        a_en = 1'b1; b_en = 1'b1;
        repeat (10) step;
        chk("pre_rst_a_oen", 32'(a_oen), 1);
        rst = 1'b1;
        #1;
        chk("midrst_a_oen", 32'(a_oen), 0);
        chk("midrst_b_oen", 32'(b_oen), 0);
        chk("midrst_a_addr", 32'(a_addr), 0);
        a_en = 1'b0; b_en = 1'b0;
        step;
        step;
        rst = 1'b0;
        for (int j = 0; j < LB + 2; j++) begin
            step;
            chk("post_rst_a_oen", 32'(a_oen), 0);
            chk("post_rst_b_oen", 32'(b_oen), 0);
        end
        single_a(5, 3, hv(8), hv(2));

        qb_s.delete(); qb_p.delete(); qb_c.delete();
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            b_in[0] = DATA_WIDTH'(2 * k);
            b_in[1] = DATA_WIDTH'(2 * k + 1);
            b_en = 1'b1;
            step;
        end
        b_en = 1'b0;
        repeat (LB + 3) step;
        chk("b_beats", qb_c.size(), 4);
        if (qb_c.size() == 4) begin
            chk("b_latency", qb_c[0] - c0, LB);
            for (int i = 0; i < 4; i++) begin
                chk("b_contig", qb_c[i] - qb_c[0], i);
                chk("b_sum", qb_s[i], hv(es[i]));
                chk("b_prod", qb_p[i], hv(3325));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
